// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo_if : receive-strobe and consumer valid/ready bundle
// Revision 1.0
// ============================================================================
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rd_ready;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;

   // The FIFO side.
   modport slave (
      input  rx_valid,
      input  rx_data,
      input  rd_ready,
      output rd_valid,
      output rd_data
   );

   // Receiver/consumer side.
   modport master (
      output rx_valid,
      output rx_data,
      output rd_ready,
      input  rd_valid,
      input  rd_data
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : FWFT byte FIFO behind a UART receiver, with sticky overflow
// Revision 1.0
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                  clk,
   input  logic                  rstn,
   uart_rx_fifo_if.slave         bus,
   input  logic                  ovf_clear_i,
   input  logic                  flush_i,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic                  overflow_o
);
   localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   C_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   C_LVL_ONE = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;

   logic w_empty, w_full, w_pop, w_push, w_drop;

   assign w_empty = (level_q == '0);
   assign w_full  = (level_q == C_DEPTH);

   // Flush swallows the concurrent strobe, so it neither stores nor counts as a drop.
   assign w_pop  = !w_empty && bus.rd_ready && !flush_i;
   assign w_push = bus.rx_valid && (!w_full || w_pop) && !flush_i;
   assign w_drop = bus.rx_valid && w_full && !w_pop && !flush_i;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
         if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         unique case ({w_push, w_pop})
            2'b10:   level_d = level_q + C_LVL_ONE;
            2'b01:   level_d = level_q - C_LVL_ONE;
            default: level_d = level_q;
         endcase
      end

      if (w_drop)           overflow_d = 1'b1;
      else if (ovf_clear_i) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= bus.rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.rd_valid  = !w_empty;
   assign bus.rd_data   = w_empty ? '0 : mem_q[rd_ptr_q];
   assign level_o       = level_q;
   assign empty_o       = w_empty;
   assign full_o        = w_full;
   assign almost_full_o = (level_q >= C_AFULL);
   assign overflow_o    = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : directed + random stimulus against a queue-based model
// Revision 1.0
// ============================================================================
module tb_uart_rx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AFULL = 12;

   logic          clk = 1'b0;
   logic          rstn;
   logic          ovf_clear;
   logic          flush;
   logic [AW:0]   level;
   logic          empty, full, almost_full, overflow;

   uart_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

   uart_rx_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .AFULL_LEVEL(AFULL)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .bus          (bus),
      .ovf_clear_i  (ovf_clear),
      .flush_i      (flush),
      .level_o      (level),
      .empty_o      (empty),
      .full_o       (full),
      .almost_full_o(almost_full),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   bit         chk_en = 1'b0;
   logic [7:0] mq[$];
   logic [7:0] popped[$];
   bit         m_ovf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a byte queue plus a sticky bit, advanced once per clock edge.
   task automatic model_step();
      bit pop, drop;
      if (!rstn) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         pop  = (mq.size() != 0) && bus.rd_ready;
         drop = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            drop = bus.rx_valid && (mq.size() == DEPTH) && !pop;
            if (pop) popped.push_back(mq.pop_front());
            if (bus.rx_valid && !drop) mq.push_back(bus.rx_data);
         end
         if (drop)           m_ovf = 1'b1;
         else if (ovf_clear) m_ovf = 1'b0;
      end
   endtask

   task automatic cycle(input bit rn, input bit rxv, input logic [7:0] d,
                        input bit rdy, input bit clr, input bit fl);
      rstn         = rn;
      bus.rx_valid = rxv;
      bus.rx_data  = d;
      bus.rd_ready = rdy;
      ovf_clear    = clr;
      flush        = fl;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_valid",    32'(bus.rd_valid), 32'(mq.size() != 0));
         chk("rd_data",     32'(bus.rd_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
         chk("level",       32'(level),        32'(mq.size()));
         chk("empty",       32'(empty),        32'(mq.size() == 0));
         chk("full",        32'(full),         32'(mq.size() == DEPTH));
         chk("almost_full", 32'(almost_full),  32'(mq.size() >= AFULL));
         chk("overflow",    32'(overflow),     32'(m_ovf));
      end
   end

   initial begin
      rstn = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
      bus.rd_ready = 1'b0; ovf_clear = 1'b0; flush = 1'b0;
      @(negedge clk);
      cycle(0, 0, 8'h00, 0, 0, 0);
      chk_en = 1'b1;
      cycle(0, 1, 8'hEE, 1, 0, 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_empty",    32'(empty),        32'd1);
      chk("rst_level",    32'(level),        32'd0);

      // Single byte in and out.
      cycle(1, 1, 8'hA5, 0, 0, 0);
      chk("a5_data",  32'(bus.rd_data), 32'hA5);
      chk("a5_level", 32'(level),       32'd1);
      chk("a5_model", 32'(mq.size()),   32'd1);
      cycle(1, 0, 8'h00, 1, 0, 0);
      chk("a5_pop_valid", 32'(bus.rd_valid), 32'd0);
      chk("a5_pop_data",  32'(bus.rd_data),  32'd0);

      // Fill to full, watching the almost-full threshold.
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 1, 8'(i), 0, 0, 0);
         if (i == AFULL - 2) chk("afull_11", 32'(almost_full), 32'd0);
         if (i == AFULL - 1) chk("afull_12", 32'(almost_full), 32'd1);
      end
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_level", 32'(level), 32'd16);

      // Drop when full, then clear.
      cycle(1, 1, 8'h55, 0, 0, 0);
      chk("drop_ovf",   32'(overflow), 32'd1);
      chk("drop_level", 32'(level),    32'd16);
      cycle(1, 0, 8'h00, 0, 1, 0);
      chk("clr_ovf", 32'(overflow), 32'd0);

      // Push while popping at full, then drain and check order.
      popped.delete();
      cycle(1, 1, 8'h77, 1, 0, 0);
      chk("pp_level", 32'(level),    32'd16);
      chk("pp_ovf",   32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'h00, 1, 0, 0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(popped.size()), 32'd17);
      for (int i = 0; i < 16; i++) chk("drain_seq", 32'(popped[i]), 32'(i));
      chk("drain_last", 32'(popped[16]), 32'h77);

      // Flush at level 5 with a concurrent strobe.
      for (int i = 0; i < 5; i++) cycle(1, 1, 8'(8'h10 + i), 0, 0, 0);
      chk("pre_flush_level", 32'(level), 32'd5);
      cycle(1, 1, 8'h33, 0, 0, 1);
      chk("flush_level", 32'(level),    32'd0);
      chk("flush_empty", 32'(empty),    32'd1);
      chk("flush_ovf",   32'(overflow), 32'd0);

      // Drop and clear together: set wins; flush then leaves it set.
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, 8'(8'h40 + i), 0, 0, 0);
      cycle(1, 1, 8'hBB, 0, 1, 0);
      chk("drop_clr_ovf", 32'(overflow), 32'd1);
      cycle(1, 0, 8'h00, 0, 0, 1);
      chk("flush_keeps_ovf", 32'(overflow), 32'd1);
      cycle(1, 0, 8'h00, 0, 1, 0);

      // Random traffic with gaps; enough writes to wrap the pointers many times.
      for (int i = 0; i < 400; i++) begin
         cycle(1, ($urandom_range(0, 99) < 50), 8'($urandom),
               ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3), 1'b0);
      end

      // Overfill then reset mid-stream.
      for (int i = 0; i < 30; i++) cycle(1, 1, 8'($urandom), 0, 0, 0);
      chk("pre_rst_ovf", 32'(overflow), 32'd1);
      cycle(0, 1, 8'h99, 1, 0, 0);
      chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
      chk("mid_rst_data",  32'(bus.rd_data),  32'd0);
      chk("mid_rst_level", 32'(level),        32'd0);
      chk("mid_rst_ovf",   32'(overflow),     32'd0);
      chk("mid_rst_afull", 32'(almost_full),  32'd0);
      cycle(1, 0, 8'h00, 0, 0, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
